// File: rtl/dsp_post_adder_pkg.sv
// Shared definitions for the DSP post-adder slice: operand select codes,
// OPMODE bit positions, datapath widths and the 49-bit add/subtract helper.
package dsp_pkg;

    localparam int P_W = 48;
    localparam int M_W = 36;

    localparam logic [1:0] X_ZERO = 2'd0;
    localparam logic [1:0] X_M    = 2'd1;
    localparam logic [1:0] X_P    = 2'd2;
    localparam logic [1:0] X_DAB  = 2'd3;

    localparam logic [1:0] Z_ZERO = 2'd0;
    localparam logic [1:0] Z_PCIN = 2'd1;
    localparam logic [1:0] Z_P    = 2'd2;
    localparam logic [1:0] Z_C    = 2'd3;

    localparam int OP_CIN = 5;
    localparam int OP_SUB = 7;

    typedef logic [P_W-1:0] p_word_t;
    typedef logic [P_W:0]   r_word_t;

    // Fields of OPMODE that steer the post-adder.
    typedef struct packed {
        logic       sub;
        logic [1:0] z_sel;
        logic [1:0] x_sel;
    } op_ctrl_t;

    function automatic op_ctrl_t decode_opmode(input logic [7:0] opmode);
        op_ctrl_t ctl;
        ctl.sub   = opmode[OP_SUB];
        ctl.z_sel = opmode[3:2];
        ctl.x_sel = opmode[1:0];
        return ctl;
    endfunction

    // Bit P_W of the result is the carry on add and the borrow on subtract.
    function automatic r_word_t post_add(input p_word_t z, input p_word_t x,
                                         input logic cin, input logic sub);
        r_word_t z_ext;
        r_word_t x_ext;
        r_word_t c_ext;
        z_ext = {1'b0, z};
        x_ext = {1'b0, x};
        c_ext = {{P_W{1'b0}}, cin};
        if (sub) begin
            return z_ext - (x_ext + c_ext);
        end
        return z_ext + x_ext + c_ext;
    endfunction

endpackage

// File: rtl/dsp_post_adder_if.sv
// Operand, control and result bundle of the post-adder. The master side
// drives operands and enables; the slave side is the post-adder itself.
interface dsp_post_adder_if;
    import dsp_pkg::*;

    logic           CEOPMODE;
    logic           CEC;
    logic           CECARRYIN;
    logic           CEP;
    logic [7:0]     OPMODE;
    logic [M_W-1:0] xmux;
    logic [P_W-1:0] DAB;
    logic [P_W-1:0] C;
    logic [P_W-1:0] PCIN;
    logic           CARRYIN;
    logic [P_W-1:0] P;
    logic [P_W-1:0] PCOUT;
    logic           CARRYOUT;
    logic           CARRYOUTF;

    modport master (
        output CEOPMODE, CEC, CECARRYIN, CEP,
        output OPMODE, xmux, DAB, C, PCIN, CARRYIN,
        input  P, PCOUT, CARRYOUT, CARRYOUTF
    );

    modport slave (
        input  CEOPMODE, CEC, CECARRYIN, CEP,
        input  OPMODE, xmux, DAB, C, PCIN, CARRYIN,
        output P, PCOUT, CARRYOUT, CARRYOUTF
    );

endinterface

// File: rtl/dsp_post_adder_dff_mux_n.sv
// Optional pipeline stage: a clock-enabled register with asynchronous
// active-low clear when pipeline=1, a plain wire when pipeline=0.
module dff_mux_n #(
    parameter int size     = 1,
    parameter int pipeline = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ce,
    input  logic [size-1:0] d,
    output logic [size-1:0] q
);

    generate
        if (pipeline != 0) begin : g_reg
            logic [size-1:0] q_r;

            // Capture d on enabled rising edges; clear at once on reset.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    q_r <= '0;
                end else if (ce) begin
                    q_r <= d;
                end
            end

            assign q = q_r;
        end else begin : g_bypass
            // Clock, reset and enable have no role in a bypassed stage.
            logic unused_ok;
            assign unused_ok = ^{clk, rst_n, ce};
            assign q = d;
        end
    endgenerate

endmodule

// File: rtl/dsp_post_adder.sv
// Post-adder / accumulator at the output end of a DSP slice. Selects X and
// Z operands from the multiplier product, P feedback, DAB, PCIN and C,
// adds or subtracts them with carry-in, and registers P and carry-out.
module dsp_post_adder
    import dsp_pkg::*;
#(
    parameter int OPMODEREG   = 1,
    parameter int CREG        = 1,
    parameter int CARRYINREG  = 1,
    parameter int CARRYOUTREG = 1,
    parameter int PREG        = 1,
    parameter int CARRYINSEL  = 0
) (
    input  logic               CLK,
    input  logic               RSTN,
    dsp_post_adder_if.slave    bus
);

    logic [7:0] opmode_q;
    p_word_t    c_q;
    logic       cin_raw;
    logic       cin_q;
    p_word_t    p_q;
    p_word_t    p_fb;
    logic       cout_q;
    op_ctrl_t   ctl;
    p_word_t    x_op;
    p_word_t    z_op;
    r_word_t    r_sum;

    // OPMODE stage; shares its timing with the multiplier M register so
    // control lines up with the product it steers.
    dff_mux_n #(.size(8), .pipeline(OPMODEREG)) u_opmode_reg (
        .clk   (CLK),
        .rst_n (RSTN),
        .ce    (bus.CEOPMODE),
        .d     (bus.OPMODE),
        .q     (opmode_q)
    );

    dff_mux_n #(.size(P_W), .pipeline(CREG)) u_c_reg (
        .clk   (CLK),
        .rst_n (RSTN),
        .ce    (bus.CEC),
        .d     (bus.C),
        .q     (c_q)
    );

    // Carry-in source is fixed at build time; the raw OPMODE bit is used
    // so the CYI stage is aligned with the registered OPMODE.
    assign cin_raw = (CARRYINSEL == 0) ? bus.OPMODE[OP_CIN] : bus.CARRYIN;

    dff_mux_n #(.size(1), .pipeline(CARRYINREG)) u_cyi_reg (
        .clk   (CLK),
        .rst_n (RSTN),
        .ce    (bus.CECARRYIN),
        .d     (cin_raw),
        .q     (cin_q)
    );

    // Feedback only ever comes from a real P register; with P bypassed it
    // is tied off so no combinational loop can form.
    assign p_fb = (PREG != 0) ? p_q : '0;

    assign ctl = decode_opmode(opmode_q);

    // Operand selection and the 49-bit add/subtract.
    always_comb begin
        x_op = '0;
        z_op = '0;
        unique case (ctl.x_sel)
            X_ZERO:  x_op = '0;
            X_M:     x_op = {{(P_W-M_W){1'b0}}, bus.xmux};
            X_P:     x_op = p_fb;
            X_DAB:   x_op = bus.DAB;
            default: x_op = '0;
        endcase
        unique case (ctl.z_sel)
            Z_ZERO:  z_op = '0;
            Z_PCIN:  z_op = bus.PCIN;
            Z_P:     z_op = p_fb;
            Z_C:     z_op = c_q;
            default: z_op = '0;
        endcase
        r_sum = post_add(z_op, x_op, cin_q, ctl.sub);
    end

    dff_mux_n #(.size(P_W), .pipeline(PREG)) u_p_reg (
        .clk   (CLK),
        .rst_n (RSTN),
        .ce    (bus.CEP),
        .d     (r_sum[P_W-1:0]),
        .q     (p_q)
    );

    // Carry-out shares the carry-in enable.
    dff_mux_n #(.size(1), .pipeline(CARRYOUTREG)) u_cyo_reg (
        .clk   (CLK),
        .rst_n (RSTN),
        .ce    (bus.CECARRYIN),
        .d     (r_sum[P_W]),
        .q     (cout_q)
    );

    assign bus.P         = p_q;
    assign bus.PCOUT     = p_q;
    assign bus.CARRYOUT  = cout_q;
    assign bus.CARRYOUTF = cout_q;

    // OPMODE[4], [6] and the registered carry bit have no use here, and
    // only one of the two carry-in sources is consumed per build.
    logic unused_ok;
    assign unused_ok = ^{opmode_q[6], opmode_q[OP_CIN], opmode_q[4],
                         bus.OPMODE[OP_CIN], bus.CARRYIN};

endmodule

// File: tb/tb_dsp_post_adder.sv
// Scoreboard bench for dsp_post_adder: stimulus pushes hand-computed
// expectations; an independent monitor pops and compares them.
module tb_dsp_post_adder;

    logic clk;
    logic rst_n;
    int   cyc;
    int   errors;
    int   checks;
    event kick;

    typedef struct {
        string       name;
        logic [47:0] p;
        logic        co;
        int          due;
    } exp_t;

    exp_t sb_q[$];

    dsp_post_adder_if bus_if ();

    dsp_post_adder u_dut (
        .CLK  (clk),
        .RSTN (rst_n),
        .bus  (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string name, input logic [47:0] act,
                             input logic [47:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: compare every due expectation against the live outputs.
    initial begin
        forever begin
            @(negedge clk or kick);
            while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
                exp_t e;
                e = sb_q.pop_front();
                check_val({e.name, ".P"},         bus_if.P,                 e.p);
                check_val({e.name, ".PCOUT"},     bus_if.PCOUT,             e.p);
                check_val({e.name, ".CARRYOUT"},  {47'b0, bus_if.CARRYOUT}, {47'b0, e.co});
                check_val({e.name, ".CARRYOUTF"}, {47'b0, bus_if.CARRYOUTF},{47'b0, e.co});
            end
        end
    end

    task automatic expect_now(input string name, input logic [47:0] p, input logic co);
        exp_t e;
        e.name = name;
        e.p    = p;
        e.co   = co;
        e.due  = cyc;
        sb_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops(input logic [7:0] op, input logic [47:0] c,
                           input logic [35:0] m);
        bus_if.OPMODE = op;
        bus_if.C      = c;
        bus_if.xmux   = m;
    endtask

    initial begin
        int waited;
        errors = 0;
        checks = 0;
        rst_n  = 1'b0;
        bus_if.CEOPMODE  = 1'b1;
        bus_if.CEC       = 1'b1;
        bus_if.CECARRYIN = 1'b1;
        bus_if.CEP       = 1'b1;
        bus_if.DAB       = '0;
        bus_if.PCIN      = '0;
        bus_if.CARRYIN   = 1'b0;
        set_ops(8'h00, 48'h0, 36'h0);

        tick(); tick();
        expect_now("reset_init", 48'h0, 1'b0);

        // Build a non-zero P, then reset asynchronously mid-cycle.
        rst_n = 1'b1;
        set_ops(8'h0D, 48'h123, 36'h5);
        tick(); expect_now("pre_rst0", 48'h0, 1'b0);
        tick(); expect_now("pre_rst1", 48'h128, 1'b0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 expect_now("async_rst", 48'h0, 1'b0);
        -> kick;
        tick(); expect_now("rst_hold0", 48'h0, 1'b0);
        tick(); expect_now("rst_hold1", 48'h0, 1'b0);

        // Add: C and OPMODE one edge ahead of xmux.
        rst_n = 1'b1;
        set_ops(8'h0D, 48'd24, 36'd0);
        tick(); expect_now("add_prime", 48'h0, 1'b0);
        bus_if.xmux = 36'd1000;
        tick(); expect_now("add", 48'd1024, 1'b0);

        // Subtract with borrow.
        set_ops(8'h8D, 48'd5, 36'd7);
        tick(); expect_now("sub_prime", 48'd31, 1'b0);
        tick(); expect_now("sub_borrow", 48'hFFFF_FFFF_FFFE, 1'b1);

        // Clear back to P=0.
        set_ops(8'h00, 48'd5, 36'd0);
        tick(); expect_now("clr0", 48'd5, 1'b0);
        tick(); expect_now("clr1", 48'd0, 1'b0);

        // Accumulate xmux=3, then hold with CEP=0.
        set_ops(8'h09, 48'd5, 36'd3);
        tick(); expect_now("acc_prime", 48'd0, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            tick(); expect_now($sformatf("acc%0d", k), 48'(3 * k), 1'b0);
        end
        bus_if.CEP = 1'b0;
        tick(); expect_now("hold0", 48'd12, 1'b0);
        tick(); expect_now("hold1", 48'd12, 1'b0);
        bus_if.CEP = 1'b1;

        // Overflow wraps to 0 with carry-out.
        set_ops(8'h0D, 48'hFFFF_FFFF_FFFF, 36'd1);
        tick(); expect_now("ovf_prime", 48'd13, 1'b0);
        tick(); expect_now("overflow", 48'h0, 1'b1);

        // Carry-in from OPMODE[5] with X=Z=0.
        bus_if.OPMODE = 8'h20;
        tick(); expect_now("cin_prime", 48'h0, 1'b1);
        tick(); expect_now("cin_only", 48'd1, 1'b0);

        // Accumulate to 9, then reset mid-accumulation.
        set_ops(8'h00, 48'hFFFF_FFFF_FFFF, 36'd3);
        tick(); expect_now("clr2", 48'd1, 1'b0);
        tick(); expect_now("clr3", 48'd0, 1'b0);
        bus_if.OPMODE = 8'h09;
        tick(); expect_now("acc2_prime", 48'd0, 1'b0);
        tick(); expect_now("acc2_3", 48'd3, 1'b0);
        tick(); expect_now("acc2_6", 48'd6, 1'b0);
        tick(); expect_now("acc2_9", 48'd9, 1'b0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 expect_now("async_rst_acc", 48'h0, 1'b0);
        -> kick;
        tick(); expect_now("rst_low_acc", 48'h0, 1'b0);
        bus_if.CEOPMODE = 1'b0;
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick(); expect_now($sformatf("post_rst%0d", k), 48'h0, 1'b0);
        end

        // DAB + PCIN, then X=P,Z=P with carry-in, then subtract.
        bus_if.CEOPMODE = 1'b1;
        bus_if.OPMODE   = 8'h07;
        bus_if.DAB      = 48'd100;
        bus_if.PCIN     = 48'd50;
        tick(); expect_now("dab_prime", 48'd0, 1'b0);
        tick(); expect_now("dab_pcin", 48'd150, 1'b0);
        bus_if.OPMODE = 8'h2A;
        tick(); expect_now("pp_prime", 48'd150, 1'b0);
        tick(); expect_now("pp_301", 48'd301, 1'b0);
        tick(); expect_now("pp_603", 48'd603, 1'b0);
        bus_if.OPMODE = 8'hAA;
        tick(); expect_now("pps_prime", 48'd1207, 1'b0);
        tick(); expect_now("pp_sub", 48'hFFFF_FFFF_FFFF, 1'b1);

        waited = 0;
        while (sb_q.size() > 0 && waited < 20) begin
            @(posedge clk);
            waited++;
        end
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", sb_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dsp_post_adder.md
Name: dsp_post_adder

Overview:
- DSP48A1 post-adder/accumulator stage. It consumes the 36-bit M-path product (xmux) and selects X and Z operands per OPMODE.
- Adds or subtracts the operands with carry-in, and registers the result into the 48-bit P register with carry-out.
- Forms the output end of the slice datapath.
- Supports accumulation via P feedback and cascade via PCIN/PCOUT.

Parameters:
- OPMODEREG, 1, 1 = register OPMODE (CYI stage aligned with MREG); 0 = combinational
- CREG, 1, 1 = register C input; 0 = bypass
- CARRYINREG, 1, 1 = register selected carry-in (CYI); 0 = bypass
- CARRYOUTREG, 1, 1 = register carry-out (CYO); 0 = bypass
- PREG, 1, 1 = register P; 0 = bypass
- CARRYINSEL, 0, 0 = carry-in from OPMODE[5]; 1 = from CARRYIN port

Ports:
- CLK  input  1  clock, rising edge
- RSTN  input  1  asynchronous active-low reset, all registers
- CEOPMODE  input  1  OPMODE register enable
- CEC  input  1  C register enable
- CECARRYIN  input  1  CYI and CYO register enable
- CEP  input  1  P register enable
- OPMODE  input  8  [1:0] X select, [3:2] Z select, [5] carry-in, [7] subtract; [4],[6] ignored here
- xmux  input  36  M-register product from the multiplier path
- DAB  input  48  concatenation {D[11:0],A[17:0],B[17:0]} formed by caller
- C  input  48  C operand
- PCIN  input  48  cascade input from previous slice
- CARRYIN  input  1  external carry-in (used when CARRYINSEL=1)
- P  output  48  result
- PCOUT  output  48  cascade out, equal to P
- CARRYOUT  output  1  carry/borrow out
- CARRYOUTF  output  1  fabric copy, equal to CARRYOUT

Behaviour:
- Reset: RSTN low clears OPMODE, C, CYI, CYO and P registers to 0 immediately, independent of CLK and enables.
  - During and after reset: P = PCOUT = 0, CARRYOUT = CARRYOUTF = 0.
  - Registered OPMODE = 0 selects X=0, Z=0, add.
- Each register updates on CLK rise only when its CE is 1; otherwise it holds.
- X mux on OPMODE[1:0]:
  - 0 → 0
  - 1 → {12'b0, xmux} (zero-extended; multiplier is unsigned)
  - 2 → P register
  - 3 → DAB
- Z mux on OPMODE[3:2]:
  - 0 → 0
  - 1 → PCIN
  - 2 → P register
  - 3 → C (registered or bypassed per CREG)
- Carry-in: CIN = OPMODE[5] (CARRYINSEL=0) or CARRYIN (CARRYINSEL=1), passed through CYI per CARRYINREG.
- Arithmetic, computed at 49 bits:
  - OPMODE[7]=0: R = {0,Z} + {0,X} + CIN
  - OPMODE[7]=1: R = {0,Z} − ({0,X} + CIN)
  - P ← R[47:0]; carry-out ← R[48] (borrow flag on subtract), passed through CYO per CARRYOUTREG.
- Wrap-around is modulo 2^48; no saturation.
- Latency, all registers enabled:
  - xmux/DAB/PCIN → P: 1 edge.
  - OPMODE, C, CARRYIN → P: 2 edges. They are sampled in the same cycle the multiplier operands enter MREG.
- P feedback (X=2 or Z=2) always uses the P register. With PREG=0 the feedback operand is forced to 0, so no combinational loop exists.
- CEP=0 during accumulation holds P. The next enabled edge continues from the held P.
- Simultaneous X=P and Z=P is legal: result is 2P + CIN, or −CIN when subtracting.
- Reset mid-operation clears state with no pending-result recovery. P stays 0 after release until a non-zero OPMODE is registered.

Decomposition:
- Shared package dsp_pkg holds:
  - X-select constants X_ZERO/X_M/X_P/X_DAB = 0..3
  - Z-select constants Z_ZERO/Z_PCIN/Z_P/Z_C = 0..3
  - OPMODE bit indices OP_CIN=5, OP_SUB=7
  - widths P_W=48, M_W=36
- One sub-module, dff_mux_n: optional pipeline register (params size, pipeline) with async active-low reset and enable. Instantiated for the OPMODE, C, CYI, CYO and P stages.

Test Plan:
- Reset: RSTN=0 mid-cycle with C=48'h123, xmux=36'h5, OPMODE=8'h0D → P=0 and CARRYOUT=0 immediately; both remain 0 while RSTN low.
- Add: OPMODE=8'h0D (X=M, Z=C), C=24 at edge n, xmux=1000 at edge n+1 → P=1024, CARRYOUT=0 after edge n+1.
- Subtract with borrow: OPMODE=8'h8D, C=5, xmux=7, CIN=0 → P=48'hFFFF_FFFF_FFFE, CARRYOUT=1.
- Accumulate: OPMODE=8'h09 (X=M, Z=P), xmux=3, P starting at 0 → P=3,6,9,12 over 4 edges; then CEP=0 for 2 edges → P holds 12.
- Overflow and carry-in:
  - OPMODE=8'h0D, C=48'hFFFF_FFFF_FFFF, xmux=1 → P=0, CARRYOUT=1.
  - OPMODE=8'h20, CARRYINSEL=0 → P=1.
- Async reset mid-accumulation at P=9 → P=0 at once; after release with CEOPMODE=0, P stays 0 across 3 edges.
